data_mem_mmio: RTL and testbench

Data-side memory block that sits directly downstream of the cpu core's ram port and consumes ram_addr_o, ram_data_o, ram_we_o and ram_ce_o. It returns load data on ram_data_i within the same cycle. Contents:
- a word-addressed data RAM;
- a small memory-mapped I/O window holding an LED register, a free-running cycle counter and a compare timer with an interrupt flag.

Word accesses only.

---
 rtl/data_mem_mmio.sv | 165 ++++++++++++++++
 tb/tb_data_mem_mmio.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// ----------------------------------------------------------------------------
// data_mem_mmio
//   Data-side memory block attached to the CPU core's RAM port. It holds a
//   word-addressed data RAM and a 256-byte MMIO window with an LED register,
//   a free-running cycle counter and a compare timer with an interrupt flag.
//   Loads are combinational (zero latency); stores commit on the rising edge.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous, active-low reset (MMIO state only)
//   ce           access enable
//   we           1 = store, 0 = load
//   addr         byte address (bits [1:0] ignored, word accesses only)
//   data_i       store data
//   data_o       load data, combinational; 0 for stores, idle or unmapped
//   led_o        LED register value
//   timer_irq_o  timer interrupt flag (registered)
// ----------------------------------------------------------------------------
module data_mem_mmio #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [15:0] led_o,
    output logic        timer_irq_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Word offsets inside the MMIO window (addr[7:2]).
    localparam logic [5:0] REG_LED   = 6'h00;
    localparam logic [5:0] REG_CYCLE = 6'h01;
    localparam logic [5:0] REG_TCMP  = 6'h02;
    localparam logic [5:0] REG_TCTRL = 6'h03;
    localparam logic [5:0] REG_TCNT  = 6'h04;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                  mmio_hit;
    logic                  ram_hit;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [5:0]            reg_sel;
    logic                  ram_we;
    logic                  mmio_we;
    logic                  unused_addr_lsb;

    assign mmio_hit        = (addr[31:8] == MMIO_BASE[31:8]);
    assign ram_hit         = !mmio_hit && (addr[31:ADDR_WIDTH+2] == '0);
    assign ram_idx         = addr[ADDR_WIDTH+1:2];
    assign reg_sel         = addr[7:2];
    assign ram_we          = ce && we && ram_hit;
    assign mmio_we         = ce && we && mmio_hit;
    assign unused_addr_lsb = ^addr[1:0];

    // ------------------------------------------------------------------
    // Data RAM (not reset)
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= data_i;
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic [15:0] led_q,   led_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] tcmp_q,  tcmp_d;
    logic [31:0] tcnt_q,  tcnt_d;
    logic        en_q,    en_d;
    logic        flag_q,  flag_d;
    logic        match;

    // Compare uses the pre-edge EN/TCNT/TCMP, so an EN set by a write only
    // starts counting on the following edge.
    assign match = en_q && (tcnt_q == tcmp_q);

    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        tcmp_d  = tcmp_q;
        tcnt_d  = tcnt_q;
        en_d    = en_q;
        flag_d  = flag_q;

        if (en_q) begin
            tcnt_d = match ? 32'd0 : tcnt_q + 32'd1;
        end

        // CPU writes come after the timer update so a TCNT write overrides
        // both increment and reload.
        if (mmio_we) begin
            unique case (reg_sel)
                REG_LED:   led_d  = data_i[15:0];
                REG_TCMP:  tcmp_d = data_i;
                REG_TCTRL: begin
                    en_d = data_i[0];
                    if (data_i[1]) begin
                        flag_d = 1'b0;
                    end
                end
                REG_TCNT:  tcnt_d = data_i;
                default:   ;
            endcase
        end

        // Set wins over write-1-to-clear on the same edge.
        if (match) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q   <= '0;
            cycle_q <= '0;
            tcmp_q  <= 32'hFFFF_FFFF;
            tcnt_q  <= '0;
            en_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
            tcmp_q  <= tcmp_d;
            tcnt_q  <= tcnt_d;
            en_q    <= en_d;
            flag_q  <= flag_d;
        end
    end

    assign led_o       = led_q;
    assign timer_irq_o = flag_q;

    // ------------------------------------------------------------------
    // Combinational read path
    // ------------------------------------------------------------------
    always_comb begin
        data_o = '0;
        if (ce && !we) begin
            if (ram_hit) begin
                data_o = mem[ram_idx];
            end else if (mmio_hit) begin
                unique case (reg_sel)
                    REG_LED:   data_o = {16'h0000, led_q};
                    REG_CYCLE: data_o = cycle_q;
                    REG_TCMP:  data_o = tcmp_q;
                    REG_TCTRL: data_o = {30'd0, flag_q, en_q};
                    REG_TCNT:  data_o = tcnt_q;
                    default:   data_o = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;

    localparam logic [31:0] A_LED   = 32'hFFFF_0000;
    localparam logic [31:0] A_CYCLE = 32'hFFFF_0004;
    localparam logic [31:0] A_TCMP  = 32'hFFFF_0008;
    localparam logic [31:0] A_TCTRL = 32'hFFFF_000C;
    localparam logic [31:0] A_TCNT  = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic [15:0] led_o;
    logic        timer_irq_o;

    int n_chk  = 0;
    int n_fail = 0;

    data_mem_mmio #(.ADDR_WIDTH(10), .MMIO_BASE(32'hFFFF_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .we          (we),
        .addr        (addr),
        .data_i      (data_i),
        .data_o      (data_o),
        .led_o       (led_o),
        .timer_irq_o (timer_irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Store at the next edge; data_o must read 0 while we=1.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d;
        #1;
        chk("data_o during store", data_o, 32'h0);
        @(posedge clk);
        #1;
        ce = 1'b0; we = 1'b0;
    endtask

    // Combinational load in the current cycle, no clock edge consumed.
    task automatic rd_now(input logic [31:0] a, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        d = data_o;
    endtask

    typedef struct {
        string       name;
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] r, c1, c2;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        rd_now(A_LED, r);   chk("rst LED", r, 32'h0);
        rd_now(A_TCTRL, r); chk("rst TCTRL", r, 32'h0);
        rd_now(A_TCNT, r);  chk("rst TCNT", r, 32'h0);
        rd_now(A_TCMP, r);  chk("rst TCMP", r, 32'hFFFF_FFFF);
        chk("rst led_o", {16'h0, led_o}, 32'h0);
        chk("rst irq", {31'h0, timer_irq_o}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rd_now(A_CYCLE, r); chk("CYCLE at release", r, 32'h0);
        rd_now(A_TCMP, r);  chk("TCMP after release", r, 32'hFFFF_FFFF);
        ce = 1'b0;

        // ---------------- table-driven RAM / LED vectors ----------------
        vecs.push_back('{"st 0x10",       1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0});
        vecs.push_back('{"ld 0x10",       1, 0, 32'h0000_0010, 0, 32'hDEAD_BEEF});
        vecs.push_back('{"ld 0x13",       1, 0, 32'h0000_0013, 0, 32'hDEAD_BEEF});
        vecs.push_back('{"ld 0x10 ce0",   0, 0, 32'h0000_0010, 0, 32'h0});
        vecs.push_back('{"st 0x0",        1, 1, 32'h0000_0000, 32'h1111_2222, 0});
        vecs.push_back('{"st unmapped",   1, 1, 32'h0001_0000, 32'h5555_5555, 0});
        vecs.push_back('{"ld 0x0",        1, 0, 32'h0000_0000, 0, 32'h1111_2222});
        vecs.push_back('{"ld unmapped",   1, 0, 32'h0001_0000, 0, 32'h0});
        vecs.push_back('{"st last word",  1, 1, 32'h0000_0FFC, 32'hA5A5_5A5A, 0});
        vecs.push_back('{"ld last word",  1, 0, 32'h0000_0FFC, 0, 32'hA5A5_5A5A});
        vecs.push_back('{"st LED",        1, 1, A_LED, 32'h1234_ABCD, 0});
        vecs.push_back('{"ld LED",        1, 0, A_LED, 0, 32'h0000_ABCD});
        vecs.push_back('{"ld LED+2",      1, 0, 32'hFFFF_0002, 0, 32'h0000_ABCD});
        vecs.push_back('{"ld MMIO 0x20",  1, 0, 32'hFFFF_0020, 0, 32'h0});
        vecs.push_back('{"ld 0xFFFF0110", 1, 0, 32'hFFFF_0110, 0, 32'h0});

        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                @(negedge clk);
                ce = vecs[i].ce; we = 1'b0; addr = vecs[i].addr;
                #1;
                chk(vecs[i].name, data_o, vecs[i].exp);
                ce = 1'b0;
            end
        end
        chk("led_o", {16'h0, led_o}, 32'h0000_ABCD);

        // ---------------- CYCLE ----------------
        @(negedge clk);
        rd_now(A_CYCLE, c1);
        repeat (5) @(posedge clk);
        #1;
        rd_now(A_CYCLE, c2);
        chk("CYCLE delta 5", c2 - c1, 32'd5);
        rd_now(A_CYCLE, c1);
        wr(A_CYCLE, 32'h0);
        rd_now(A_CYCLE, c2);
        chk("CYCLE store ignored", c2 - c1, 32'd1);

        // ---------------- timer period ----------------
        wr(A_TCMP, 32'd3);
        wr(A_TCNT, 32'd0);
        wr(A_TCTRL, 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            rd_now(A_TCNT, r);
            chk($sformatf("TCNT step %0d", i), r, (i == 4) ? 32'd0 : 32'(i));
            chk($sformatf("irq step %0d", i), {31'h0, timer_irq_o}, (i == 4) ? 32'd1 : 32'd0);
        end

        // Clear FLAG while keeping EN=1.
        wr(A_TCTRL, 32'h3);
        chk("irq cleared", {31'h0, timer_irq_o}, 32'd0);
        rd_now(A_TCTRL, r); chk("TCTRL EN kept", r, 32'h1);
        rd_now(A_TCNT, r);  chk("TCNT after clear", r, 32'd1);

        // ---------------- set beats clear ----------------
        wr(A_TCNT, 32'd3);
        chk("irq before match", {31'h0, timer_irq_o}, 32'd0);
        rd_now(A_TCNT, r);  chk("TCNT written", r, 32'd3);
        wr(A_TCTRL, 32'h3);
        chk("set beats clear irq", {31'h0, timer_irq_o}, 32'd1);
        rd_now(A_TCTRL, r); chk("set beats clear TCTRL", r, 32'h3);
        rd_now(A_TCNT, r);  chk("reload on match", r, 32'd0);

        // ---------------- async reset mid-count ----------------
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_now(A_TCNT, r);  chk("TCNT before rst", r, 32'd2);
        #1;
        rst = 1'b0;
        #1;
        rd_now(A_TCNT, r);  chk("async rst TCNT", r, 32'h0);
        rd_now(A_TCTRL, r); chk("async rst TCTRL", r, 32'h0);
        rd_now(A_LED, r);   chk("async rst LED", r, 32'h0);
        rd_now(A_TCMP, r);  chk("async rst TCMP", r, 32'hFFFF_FFFF);
        chk("async rst led_o", {16'h0, led_o}, 32'h0);
        chk("async rst irq", {31'h0, timer_irq_o}, 32'h0);
        rd_now(32'h0000_0010, r); chk("RAM kept over rst", r, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rd_now(A_CYCLE, r); chk("CYCLE held in rst", r, 32'h0);
        @(posedge clk); #1;
        rd_now(A_CYCLE, r); chk("CYCLE resumes", r, 32'h1);
        rd_now(A_TCNT, r);  chk("TCNT idle after rst", r, 32'h0);
        ce = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
